link_ring_ctrl: RTL and testbench
=================================

# link_ring_ctrl

Token-ring controller that sequences a chain of `link_i` stages in the distributed-simulation example. It injects a sequenced token at the ring head and waits for it to return at the ring tail. On return it checks the token, records round-trip latency and round count, then re-injects; it flags lost or corrupted tokens. It replaces the hard-wired startup injection of stage ID 0 with an explicit start/stop/error-handling sequencer.

## Interface
- `TIMEOUT`, 64: cycles in WAIT without a return before the token is declared lost (≥2).
- `CTRL_ID`, 32'hFFFF_FFFF: value driven on `o_id` during injection.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_start` in 1: level; starts a run from IDLE.
- `i_stop` in 1: pulse; end the run after the current round completes.
- `i_err_clr` in 1: pulse; leave ERR.
- `o_wen` out 1: ring-head write enable, 1-cycle pulse per round.
- `o_token` out 32: token sent, held stable from INJECT until the next INJECT.
- `o_clk_cnt` out 32: free-running cycle counter.
- `o_id` out 32: `CTRL_ID` while `o_wen`=1, else 0.
- `i_wen` in 1: ring-tail write enable (token return).
- `i_token` in 32: returned token, valid the cycle after `i_wen`.
- `i_clk_cnt` in 32: ring-tail count, unused.
- `i_id` in 32: ring-tail ID, unused.
- `o_busy` out 1: state ≠ IDLE and ≠ ERR.
- `o_err` out 1: 1 in ERR.
- `o_round_cnt` out 32: completed good rounds since reset.
- `o_lat` out 32: last good round-trip latency in cycles.

## Operation
- FSM states: IDLE, INJECT, WAIT, CHECK, ERR.
- **IDLE**: `o_wen`=0. If `i_start`=1 and `i_stop`=0, go to INJECT. Start and stop together: stay in IDLE.
- **INJECT** (1 cycle):
  - Register `o_wen`=1, `o_token`=`seq`, `o_id`=`CTRL_ID`.
  - Clear `timer`; go to WAIT.
- **WAIT**:
  - `timer` increments each cycle.
  - `i_wen`=1: latch `lat`=`timer`+1; go to CHECK.
  - Otherwise, `timer`=`TIMEOUT`-1: go to ERR.
  - If `i_wen` arrives on the same cycle as the timeout, `i_wen` wins.
- **CHECK** (1 cycle): sample `i_token`.
  - Token ≠ `seq`: go to ERR; `o_round_cnt`, `o_lat` and `seq` are unchanged.
  - Token = `seq`: `o_round_cnt`++, `o_lat`=`lat`, `seq`++. Go to IDLE if `stop_pend`, else INJECT.
- **ERR**: `o_err`=1; `i_wen` is ignored. `i_err_clr` goes to IDLE and clears `stop_pend`; `seq` is kept.
- `stop_pend`:
  - Set by `i_stop` in INJECT, WAIT or CHECK.
  - Cleared on entry to IDLE.
  - `i_stop` in IDLE or ERR is ignored.
- `i_wen` outside WAIT is ignored.
- Arithmetic: `seq`, `o_round_cnt` and `o_clk_cnt` are 32-bit and wrap silently at 2^32. `timer` is `$clog2(TIMEOUT)+1` bits and never overflows.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, `seq`=0, `stop_pend`=0.
- Reset is asynchronous: asserting `i_rst` mid-round forces the reset values immediately, with no return to complete.
- Start latency: `i_start` high at edge k → `o_wen`=1 in cycle k+1.
- Round cadence: INJECT, WAIT (D cycles), CHECK, so re-injection happens D+2 cycles after the previous `o_wen`.
- With a ring delay of D cycles from `o_wen` to `i_wen`, `o_lat`=D.
- Timeout: `o_err` rises `TIMEOUT`+1 cycles after the `o_wen` cycle.
- `o_id` returns to 0 the cycle after `o_wen`. `o_token` persists until the next INJECT.

## Structure
- Package `link_ring_pkg`: state enum `ring_state_t` {IDLE, INJECT, WAIT, CHECK, ERR} and a default `CTRL_ID` constant.
- The block is monolithic; no sub-module is required.
- Expected size: about 150 lines of RTL.

## Test plan
- **Reset**: assert `i_rst` → all outputs 0 and `o_busy`=0; `i_wen` pulses while idle are ignored.
- **Loopback**: bench loopback with D=8 echoing the token one cycle after `i_wen`; hold `i_start` → `o_wen` pulses every 10 cycles with `o_token`=0,1,2…; after 3 rounds `o_round_cnt`=3 and `o_lat`=8.
- **Stop mid-WAIT**: pulse `i_stop` 3 cycles after `o_wen` → round completes, `o_round_cnt`+1, then IDLE with `o_busy`=0; no further `o_wen` even with `i_start` low.
- **Lost token**: no return, `TIMEOUT`=64 → `o_err`=1 at cycle 65 after `o_wen`, `o_round_cnt` unchanged; pulse `i_err_clr` → IDLE; restart → `o_token` equals the pre-error `seq`.
- **Corrupted token**: return `seq` XOR 1 → `o_err`=1 after CHECK, `o_lat` keeps its previous value.
- **Async reset mid-WAIT**: assert `i_rst` between clock edges → outputs 0 at once; on release, state is IDLE and `o_round_cnt`=0.

Source files
------------

// File: rtl/link_ring_pkg.sv
// Shared types and constants for the token-ring controller.
package link_ring_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INJECT,
    WAIT,
    CHECK,
    ERR
  } ring_state_t;

  localparam logic [31:0] CTRL_ID_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/link_ring_ctrl.sv
// Token-ring sequencer: injects a sequenced token at the ring head, checks its
// return at the ring tail, tracks round count and latency, and flags lost/bad tokens.
module link_ring_ctrl
  import link_ring_pkg::*;
#(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] CTRL_ID = CTRL_ID_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_err_clr,
  output logic        o_wen,
  output logic [31:0] o_token,
  output logic [31:0] o_clk_cnt,
  output logic [31:0] o_id,
  input  logic        i_wen,
  input  logic [31:0] i_token,
  input  logic [31:0] i_clk_cnt,
  input  logic [31:0] i_id,
  output logic        o_busy,
  output logic        o_err,
  output logic [31:0] o_round_cnt,
  output logic [31:0] o_lat
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  ring_state_t   state_reg;
  logic [31:0]   seq_reg;
  logic [31:0]   seq_next;
  logic [TW-1:0] timer_reg;
  logic [31:0]   lat_reg;
  logic          stop_pend_reg;

  // Ring-tail count and ID carry no information this controller needs.
  logic unused_tail;
  assign unused_tail = ^{i_clk_cnt, i_id};

  assign seq_next = seq_reg + 32'd1;

  // Outputs are registered together with the transition into the state they belong to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      seq_reg       <= 32'd0;
      timer_reg     <= '0;
      lat_reg       <= 32'd0;
      stop_pend_reg <= 1'b0;
      o_wen         <= 1'b0;
      o_token       <= 32'd0;
      o_clk_cnt     <= 32'd0;
      o_id          <= 32'd0;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
      o_round_cnt   <= 32'd0;
      o_lat         <= 32'd0;
    end else begin
      o_clk_cnt <= o_clk_cnt + 32'd1;
      o_wen     <= 1'b0;
      o_id      <= 32'd0;
      case (state_reg)
        IDLE: begin
          if (i_start && !i_stop) begin
            state_reg <= INJECT;
            o_wen     <= 1'b1;
            o_id      <= CTRL_ID;
            o_token   <= seq_reg;
            o_busy    <= 1'b1;
          end
        end
        INJECT: begin
          if (i_stop) stop_pend_reg <= 1'b1;
          timer_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (i_stop) stop_pend_reg <= 1'b1;
          // A return on the timeout cycle still counts as a return.
          if (i_wen) begin
            lat_reg   <= 32'(timer_reg) + 32'd1;
            state_reg <= CHECK;
          end else if (timer_reg == TIMER_LAST) begin
            state_reg <= ERR;
            o_busy    <= 1'b0;
            o_err     <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        CHECK: begin
          if (i_token != seq_reg) begin
            if (i_stop) stop_pend_reg <= 1'b1;
            state_reg <= ERR;
            o_busy    <= 1'b0;
            o_err     <= 1'b1;
          end else begin
            o_round_cnt <= o_round_cnt + 32'd1;
            o_lat       <= lat_reg;
            seq_reg     <= seq_next;
            if (stop_pend_reg || i_stop) begin
              state_reg     <= IDLE;
              stop_pend_reg <= 1'b0;
              o_busy        <= 1'b0;
            end else begin
              state_reg <= INJECT;
              o_wen     <= 1'b1;
              o_id      <= CTRL_ID;
              o_token   <= seq_next;
            end
          end
        end
        ERR: begin
          if (i_err_clr) begin
            state_reg     <= IDLE;
            stop_pend_reg <= 1'b0;
            o_err         <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          o_busy    <= 1'b0;
          o_err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_ring_ctrl.sv
// Scoreboard bench for link_ring_ctrl: a ring emulator returns tokens, a model
// predicts injections and round outcomes, and a monitor compares them.
module tb_link_ring_ctrl;

  localparam int          TIMEOUT = 64;
  localparam logic [31:0] CTRL_ID = 32'hFFFF_FFFF;
  localparam int MODE_GOOD = 0, MODE_CORRUPT = 1, MODE_DROP = 2;

  typedef struct { int d; int mode; } ring_cfg_t;
  typedef struct { logic [31:0] tok; int gap; } inj_t;
  typedef struct { logic [31:0] round; logic [31:0] lat; } done_t;
  typedef struct { logic [31:0] round; logic [31:0] lat; int gap; } err_t;

  logic i_clk = 1'b0, i_rst = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_err_clr = 1'b0;
  logic ring_wen = 1'b0, main_wen = 1'b0;
  logic [31:0] ring_tok = 32'd0, tail_cnt = 32'd0, tail_id = 32'd0;
  logic i_wen;
  logic o_wen, o_busy, o_err;
  logic [31:0] o_token, o_clk_cnt, o_id, o_round_cnt, o_lat;

  assign i_wen = ring_wen | main_wen;

  int tests = 0, fails = 0;
  ring_cfg_t cfg_q[$];
  inj_t      inj_q[$];
  done_t     done_q[$];
  err_t      err_q[$];
  logic [31:0] m_seq = 32'd0, m_round = 32'd0, m_lat = 32'd0;
  logic [31:0] exp_clk = 32'd0;

  link_ring_ctrl #(.TIMEOUT(TIMEOUT), .CTRL_ID(CTRL_ID)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_err_clr(i_err_clr), .o_wen(o_wen), .o_token(o_token), .o_clk_cnt(o_clk_cnt),
    .o_id(o_id), .i_wen(i_wen), .i_token(ring_tok), .i_clk_cnt(tail_cnt),
    .i_id(tail_id), .o_busy(o_busy), .o_err(o_err), .o_round_cnt(o_round_cnt),
    .o_lat(o_lat)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) exp_clk <= 32'd0;
    else       exp_clk <= exp_clk + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic event_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: actual=missing/extra event required=scoreboard match", name);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_wen"}, 32'(o_wen), 32'd0);
    check({pfx, "_token"}, o_token, 32'd0);
    check({pfx, "_clk_cnt"}, o_clk_cnt, 32'd0);
    check({pfx, "_id"}, o_id, 32'd0);
    check({pfx, "_busy"}, 32'(o_busy), 32'd0);
    check({pfx, "_err"}, 32'(o_err), 32'd0);
    check({pfx, "_round_cnt"}, o_round_cnt, 32'd0);
    check({pfx, "_lat"}, o_lat, 32'd0);
  endtask

  // Ring emulator: echoes the injected token D cycles after o_wen, valid one cycle later.
  ring_cfg_t   r_cfg;
  logic [31:0] r_tok;
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_wen === 1'b1 && cfg_q.size() > 0) begin
        r_cfg = cfg_q.pop_front();
        r_tok = o_token;
        if (r_cfg.mode != MODE_DROP) begin
          repeat (r_cfg.d) @(negedge i_clk);
          ring_wen = 1'b1;
          ring_tok = $urandom;
          @(negedge i_clk);
          ring_wen = 1'b0;
          ring_tok = (r_cfg.mode == MODE_CORRUPT) ? (r_tok ^ 32'd1) : r_tok;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  int mon_cyc = 0, last_wen = 0;
  logic [31:0] prev_round = 32'd0;
  logic prev_err = 1'b0;
  inj_t  e_inj;
  done_t e_done;
  err_t  e_err;
  initial begin
    forever begin
      @(negedge i_clk);
      mon_cyc++;
      if (i_rst) begin
        prev_round = o_round_cnt;
        prev_err   = o_err;
      end else begin
        check("clk_cnt", o_clk_cnt, exp_clk);
        if (o_wen) begin
          if (inj_q.size() == 0) event_fail("unexpected_wen");
          else begin
            e_inj = inj_q.pop_front();
            check("inj_token", o_token, e_inj.tok);
            check("inj_id", o_id, CTRL_ID);
            if (e_inj.gap > 0) check("inj_gap", 32'(mon_cyc - last_wen), 32'(e_inj.gap));
          end
          last_wen = mon_cyc;
        end else begin
          check("id_idle", o_id, 32'd0);
        end
        if (o_round_cnt != prev_round) begin
          if (done_q.size() == 0) event_fail("unexpected_round");
          else begin
            e_done = done_q.pop_front();
            check("round_cnt", o_round_cnt, e_done.round);
            check("round_lat", o_lat, e_done.lat);
          end
        end
        if (o_err && !prev_err) begin
          if (err_q.size() == 0) event_fail("unexpected_err");
          else begin
            e_err = err_q.pop_front();
            check("err_round_cnt", o_round_cnt, e_err.round);
            check("err_lat", o_lat, e_err.lat);
            check("err_delay", 32'(mon_cyc - last_wen), 32'(e_err.gap));
          end
        end
        prev_round = o_round_cnt;
        prev_err   = o_err;
      end
    end
  end

  task automatic wait_wen(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge i_clk);
      seen = o_wen;
    end
  endtask

  // n good rounds with held start; stop pulsed during the last round.
  task automatic run_good(input int n, input int dfix);
    int d[$];
    int cnt;
    bit seen;
    for (int i = 0; i < n; i++) begin
      d.push_back(dfix > 0 ? dfix : int'($urandom_range(20, 1)));
      cfg_q.push_back(ring_cfg_t'{d: d[i], mode: MODE_GOOD});
      inj_q.push_back(inj_t'{tok: m_seq, gap: (i == 0) ? 0 : d[i-1] + 2});
      m_seq   = m_seq + 32'd1;
      m_round = m_round + 32'd1;
      m_lat   = 32'(d[i]);
      done_q.push_back(done_t'{round: m_round, lat: m_lat});
    end
    i_start = 1'b1;
    @(negedge i_clk);
    check("start_latency", 32'(o_wen), 32'd1);
    cnt = o_wen ? 1 : 0;
    while (cnt < n) begin
      wait_wen(seen);
      if (!seen) begin
        event_fail("wen_timeout");
        break;
      end
      cnt++;
    end
    i_start = 1'b0;
    repeat ($urandom_range(d[n-1], 0)) @(negedge i_clk);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    for (int i = 0; i < 200 && o_busy; i++) @(negedge i_clk);
    check("busy_after_stop", 32'(o_busy), 32'd0);
    check("final_round_cnt", o_round_cnt, m_round);
    check("final_lat", o_lat, m_lat);
    repeat (12) @(negedge i_clk);
  endtask

  task automatic run_err(input int mode, input int d);
    bit seen;
    cfg_q.push_back(ring_cfg_t'{d: d, mode: mode});
    inj_q.push_back(inj_t'{tok: m_seq, gap: 0});
    err_q.push_back(err_t'{round: m_round, lat: m_lat,
                           gap: (mode == MODE_DROP) ? TIMEOUT + 1 : d + 2});
    i_start = 1'b1;
    @(negedge i_clk);
    check("err_start_latency", 32'(o_wen), 32'd1);
    i_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 20 && !seen; i++) begin
      @(negedge i_clk);
      seen = o_err;
    end
    if (!seen) event_fail("err_timeout");
    main_wen = 1'b1;
    i_stop   = 1'b1;
    @(negedge i_clk);
    main_wen = 1'b0;
    i_stop   = 1'b0;
    repeat (3) @(negedge i_clk);
    check("err_hold", 32'(o_err), 32'd1);
    check("err_busy", 32'(o_busy), 32'd0);
    check("err_round_hold", o_round_cnt, m_round);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    check("err_clear", 32'(o_err), 32'd0);
    check("err_clear_busy", 32'(o_busy), 32'd0);
    repeat (4) @(negedge i_clk);
  endtask

  bit seen_main;
  initial begin
    tail_cnt = $urandom;
    tail_id  = $urandom;
    #1 i_rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    // Returns while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      main_wen = 1'b1;
      ring_tok = $urandom;
      @(negedge i_clk);
      main_wen = 1'b0;
      @(negedge i_clk);
    end
    check("idle_wen_busy", 32'(o_busy), 32'd0);
    check("idle_wen_round", o_round_cnt, 32'd0);
    check("idle_wen_lat", o_lat, 32'd0);

    run_good(3, 8);
    check("loopback_rounds", o_round_cnt, 32'd3);
    check("loopback_lat", o_lat, 32'd8);

    // Start and stop together in idle: stay idle.
    i_start = 1'b1;
    i_stop  = 1'b1;
    repeat (4) @(negedge i_clk);
    check("start_stop_busy", 32'(o_busy), 32'd0);
    i_start = 1'b0;
    i_stop  = 1'b0;
    repeat (2) @(negedge i_clk);

    run_good(5, 0);
    run_good(1, TIMEOUT);
    run_good(1, 1);

    run_err(MODE_DROP, 0);
    run_good(1, 0);
    run_err(MODE_CORRUPT, int'($urandom_range(20, 1)));
    run_good(2, 0);

    // Asynchronous reset in the middle of a WAIT.
    cfg_q.push_back(ring_cfg_t'{d: 30, mode: MODE_GOOD});
    inj_q.push_back(inj_t'{tok: m_seq, gap: 0});
    i_start = 1'b1;
    wait_wen(seen_main);
    if (!seen_main) event_fail("async_wen_timeout");
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_all_zero("async_reset");
    cfg_q.delete();
    inj_q.delete();
    done_q.delete();
    err_q.delete();
    m_seq   = 32'd0;
    m_round = 32'd0;
    m_lat   = 32'd0;
    repeat (40) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_reset_round", o_round_cnt, 32'd0);
    check("post_reset_busy", 32'(o_busy), 32'd0);
    run_good(2, 0);

    check("inj_q_drained", 32'(inj_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
